// File: rtl/float_arb_pkg.sv
// Shared types and constants for the float adder arbiter.
package float_arb_pkg;

  localparam int FLOAT_W     = 32;
  localparam int NUM_REQ_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GRANT  = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RETURN = 3'd4
  } arb_state_e;

endpackage

// File: rtl/float_adder_arbiter_rr_grant.sv
// Combinational grant picker: round-robin from a pointer when FLOAT_ADDER_ARB_RR_EN
// is defined, otherwise fixed priority with requester 0 highest.
module rr_grant #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
`ifdef FLOAT_ADDER_ARB_RR_EN
  input  logic [IDX_W-1:0]   ptr_i,
`endif
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

`ifdef FLOAT_ADDER_ARB_RR_EN
  localparam logic [IDX_W:0] NUM_L = NUM_REQ[IDX_W:0];

  logic [NUM_REQ-1:0] rot;
  logic [IDX_W-1:0]   off;
  logic [IDX_W:0]     sum;

  // Rotate so the pointer position lands at bit 0, pick the lowest set bit,
  // then map the offset back to an absolute index modulo NUM_REQ.
  always_comb begin
    rot = NUM_REQ'({req_i, req_i} >> ptr_i);
    off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) off = IDX_W'(k);
    end
    sum = {1'b0, ptr_i} + {1'b0, off};
    if (sum >= NUM_L) sum = sum - NUM_L;
    idx_o   = sum[IDX_W-1:0];
    valid_o = |req_i;
    gnt_o   = valid_o ? (NUM_REQ'(1) << idx_o) : '0;
  end
`else
  always_comb begin
    idx_o = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_i[k]) idx_o = IDX_W'(k);
    end
    valid_o = |req_i;
    gnt_o   = valid_o ? (NUM_REQ'(1) << idx_o) : '0;
  end
`endif

endmodule

// File: rtl/float_adder_arbiter.sv
// Shares one STB/ACK float adder among NUM_REQ requesters.
// FLOAT_ADDER_ARB_RR_EN selects round-robin; undefined gives fixed priority.
module float_adder_arbiter
  import float_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF
) (
  input  logic                       i_CLK,
  input  logic                       i_RST,
  input  logic [FLOAT_W*NUM_REQ-1:0] i_REQ_A,
  input  logic [FLOAT_W*NUM_REQ-1:0] i_REQ_B,
  input  logic [NUM_REQ-1:0]         i_REQ_AB_STB,
  output logic [NUM_REQ-1:0]         o_REQ_AB_ACK,
  output logic [FLOAT_W-1:0]         o_REQ_Z,
  output logic [NUM_REQ-1:0]         o_REQ_Z_STB,
  input  logic [NUM_REQ-1:0]         i_REQ_Z_ACK,
  output logic [FLOAT_W-1:0]         o_ADD_A,
  output logic [FLOAT_W-1:0]         o_ADD_B,
  output logic                       o_ADD_AB_STB,
  input  logic                       i_ADD_AB_ACK,
  input  logic [FLOAT_W-1:0]         i_ADD_Z,
  input  logic                       i_ADD_Z_STB,
  output logic                       o_ADD_Z_ACK,
  output logic                       o_BUSY
);

  // state     | meaning
  // ST_IDLE   | no op in flight, pick a requester when any STB is high
  // ST_GRANT  | ack granted requester, capture its operands or abandon
  // ST_ISSUE  | present captured operands to the adder
  // ST_WAIT   | accept the adder result
  // ST_RETURN | hold sum for the granted requester until it acks

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    g_q, g_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [FLOAT_W-1:0]  a_q, a_d, b_q, b_d, z_q, z_d;
  logic [FLOAT_W-1:0]  a_sel, b_sel;
  logic [NUM_REQ-1:0]  rr_gnt;
  logic [IDX_W-1:0]    rr_idx;
  logic                rr_valid;

`ifdef FLOAT_ADDER_ARB_RR_EN
  logic [IDX_W-1:0]    p_q, p_d;
`endif

  rr_grant #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_grant (
    .req_i   (i_REQ_AB_STB),
`ifdef FLOAT_ADDER_ARB_RR_EN
    .ptr_i   (p_q),
`endif
    .gnt_o   (rr_gnt),
    .idx_o   (rr_idx),
    .valid_o (rr_valid)
  );

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int n = 0; n < NUM_REQ; n++) begin
      if (g_q == IDX_W'(n)) begin
        a_sel = i_REQ_A[n*FLOAT_W +: FLOAT_W];
        b_sel = i_REQ_B[n*FLOAT_W +: FLOAT_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    gnt_d   = gnt_q;
    a_d     = a_q;
    b_d     = b_q;
    z_d     = z_q;
`ifdef FLOAT_ADDER_ARB_RR_EN
    p_d     = p_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (rr_valid) begin
          g_d     = rr_idx;
          gnt_d   = rr_gnt;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // A requester that withdrew is dropped without advancing the pointer.
        if (|(i_REQ_AB_STB & gnt_q)) begin
          a_d     = a_sel;
          b_d     = b_sel;
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (i_ADD_AB_ACK) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_ADD_Z_STB) begin
          z_d     = i_ADD_Z;
          state_d = ST_RETURN;
        end
      end
      ST_RETURN: begin
        if (|(i_REQ_Z_ACK & gnt_q)) begin
`ifdef FLOAT_ADDER_ARB_RR_EN
          p_d = (g_q == LAST_IDX) ? '0 : g_q + 1'b1;
`endif
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_q <= ST_IDLE;
      g_q     <= '0;
      gnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      z_q     <= '0;
`ifdef FLOAT_ADDER_ARB_RR_EN
      p_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      gnt_q   <= gnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      z_q     <= z_d;
`ifdef FLOAT_ADDER_ARB_RR_EN
      p_q     <= p_d;
`endif
    end
  end

  // Strobes decode from registered state and grant only.
  assign o_REQ_AB_ACK = (state_q == ST_GRANT)  ? gnt_q : '0;
  assign o_REQ_Z_STB  = (state_q == ST_RETURN) ? gnt_q : '0;
  assign o_ADD_AB_STB = (state_q == ST_ISSUE);
  assign o_ADD_Z_ACK  = (state_q == ST_WAIT);
  assign o_BUSY       = (state_q != ST_IDLE);
  assign o_ADD_A      = a_q;
  assign o_ADD_B      = b_q;
  assign o_REQ_Z      = z_q;

endmodule
